// File: rtl/prim_clock_gate_ctrl.sv
// rtl/prim_clock_gate_ctrl.sv - enable controller for a clock-gating primitive
// Runs on the ungated clock; idles, requests quiesce, gates, and wakes with a minimum on-time.

module prim_clock_gate_ctrl #(
  parameter int IdleCycles = 16,
  parameter int HoldCycles = 8,
  parameter int CntW       = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            gate_en_i,
  input  logic            activity_i,
  input  logic            wake_i,
  input  logic            ack_i,
  output logic            req_o,
  output logic            clk_en_o,
  output logic            gated_o,
  output logic [CntW-1:0] wake_cnt_o
);

  localparam int IdleW = $clog2(IdleCycles + 1);
  localparam int HoldW = (HoldCycles > 0) ? $clog2(HoldCycles + 1) : 1;
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IdleCycles - 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HoldCycles);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_QREQ,
    ST_GATED,
    ST_WAKE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IdleW-1:0]  r_idle_cnt;
  logic [IdleW-1:0]  w_idle_nxt;
  logic [HoldW-1:0]  r_hold_cnt;
  logic [HoldW-1:0]  w_hold_nxt;
  logic [CntW-1:0]   r_wake_cnt;
  logic [CntW-1:0]   w_wake_nxt;
  logic              r_clk_en;
  logic              r_req;
  logic              r_gated;
  logic              w_wake_cond;

  assign w_wake_cond = activity_i | wake_i | ~gate_en_i;

  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_wake_nxt  = r_wake_cnt;
    case (r_state)
      ST_RUN: begin
        if (r_hold_cnt != '0) begin
          w_hold_nxt = r_hold_cnt - 1'b1;
          w_idle_nxt = '0;
        end else if (w_wake_cond) begin
          w_idle_nxt = '0;
        end else if (r_idle_cnt == IdleLast) begin
          w_state_nxt = ST_QREQ;
          w_idle_nxt  = '0;
        end else begin
          w_idle_nxt = r_idle_cnt + 1'b1;
        end
      end
      // An abort wins over a simultaneous ack so the clock is never cut under live work.
      ST_QREQ: begin
        if (w_wake_cond) begin
          w_state_nxt = ST_WAKE;
        end else if (ack_i) begin
          w_state_nxt = ST_GATED;
        end
      end
      ST_GATED: begin
        if (w_wake_cond) begin
          w_state_nxt = ST_WAKE;
          if (r_wake_cnt != '1) begin
            w_wake_nxt = r_wake_cnt + 1'b1;
          end
        end
      end
      ST_WAKE: begin
        if (!ack_i) begin
          w_state_nxt = ST_RUN;
          w_hold_nxt  = HoldLoad;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Outputs are registered from the next state so they change only on clock edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_RUN;
      r_idle_cnt <= '0;
      r_hold_cnt <= '0;
      r_wake_cnt <= '0;
      r_clk_en   <= 1'b1;
      r_req      <= 1'b0;
      r_gated    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_wake_cnt <= w_wake_nxt;
      r_clk_en   <= (w_state_nxt != ST_GATED);
      r_req      <= (w_state_nxt == ST_QREQ) || (w_state_nxt == ST_GATED);
      r_gated    <= (w_state_nxt == ST_GATED);
    end
  end

  assign clk_en_o   = r_clk_en;
  assign req_o      = r_req;
  assign gated_o    = r_gated;
  assign wake_cnt_o = r_wake_cnt;

endmodule
